// File: rtl/alu_pkg.sv
// Shared types for the ALU execution stage: opcode and FSM state encodings.
// Default operand width used by the ALU modules.
package alu_pkg;

  localparam int ALU_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_MUL = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier, built only with ALU_EXEC_MUL_EN; done is high DATA_WIDTH
// cycles after start, and product is valid in that cycle. No backpressure: the caller samples on done.
`ifdef ALU_EXEC_MUL_EN
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic                    done,
  output logic [2*DATA_WIDTH-1:0] product
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [2*DATA_WIDTH-1:0] mcand;
  logic [2*DATA_WIDTH-1:0] acc;
  logic [2*DATA_WIDTH-1:0] acc_nxt;
  logic [DATA_WIDTH-1:0]   mplier;
  logic [CW-1:0]           cnt;
  logic                    run;

  // The last partial product is folded in combinationally so the result is ready on the done cycle.
  assign acc_nxt = acc + (mplier[0] ? mcand : '0);
  assign done    = run && (cnt == CW'(DATA_WIDTH - 1));
  assign product = acc_nxt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      run    <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      run    <= 1'b1;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= {{DATA_WIDTH{1'b0}}, a};
      mplier <= b;
    end else if (run) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (done) run <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/alu_exec.sv
// ALU execution stage: launch on rising execute[0], result after 2 edges (DATA_WIDTH+1 for MUL when
// ALU_EXEC_MUL_EN is defined); result held in DONE until res_ready, launches while busy set dropped.
module alu_exec
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH,
  parameter int EXEC_WIDTH = 17
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   A_reg,
  input  logic [DATA_WIDTH-1:0]   B_reg,
  input  logic [DATA_WIDTH-1:0]   OPER,
  input  logic [EXEC_WIDTH-1:0]   execute,
  output logic [2*DATA_WIDTH-1:0] res_data,
  output logic                    res_carry,
  output logic                    res_zero,
  output logic                    res_illegal,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic                    busy,
  output logic                    dropped
);

  localparam int DW = DATA_WIDTH;
  localparam int SW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  alu_state_e      state;
  logic            exe_q;
  logic            launch;
  logic [DW-1:0]   a_q;
  logic [DW-1:0]   b_q;
  alu_op_e         op_q;
  logic [2*DW-1:0] calc_data;
  logic            calc_carry;
  logic            calc_ill;
  logic            unused_bits;

  assign launch      = execute[0] & ~exe_q;
  assign unused_bits = ^{OPER[DW-1:3], execute[EXEC_WIDTH-1:1]};

`ifdef ALU_EXEC_MUL_EN
  logic            mul_start;
  logic            mul_done;
  logic [2*DW-1:0] mul_product;

  assign mul_start = (state == ST_IDLE) && launch && (OPER[2:0] == OP_MUL);

  alu_mul_seq #(.DATA_WIDTH(DW)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (A_reg),
    .b       (B_reg),
    .done    (mul_done),
    .product (mul_product)
  );
`endif

  always_comb begin
    calc_data  = '0;
    calc_carry = 1'b0;
    calc_ill   = 1'b0;
    case (op_q)
      OP_ADD: begin
        calc_data  = {{(DW-1){1'b0}}, {1'b0, a_q} + {1'b0, b_q}};
        calc_carry = calc_data[DW];
      end
      OP_SUB: begin
        calc_data  = {{DW{1'b0}}, a_q - b_q};
        calc_carry = (a_q < b_q);
      end
      OP_AND: calc_data = {{DW{1'b0}}, a_q & b_q};
      OP_OR:  calc_data = {{DW{1'b0}}, a_q | b_q};
      OP_XOR: calc_data = {{DW{1'b0}}, a_q ^ b_q};
      OP_MUL: begin
`ifndef ALU_EXEC_MUL_EN
        // Without the multiplier, MUL completes as a zero result flagged illegal.
        calc_ill = 1'b1;
`endif
      end
      OP_SHL: calc_data = {{DW{1'b0}}, a_q} << b_q[SW-1:0];
      OP_SHR: calc_data = {{DW{1'b0}}, a_q >> b_q[SW-1:0]};
      default: calc_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      exe_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_ADD;
      res_data    <= '0;
      res_carry   <= 1'b0;
      res_zero    <= 1'b0;
      res_illegal <= 1'b0;
      res_valid   <= 1'b0;
      busy        <= 1'b0;
      dropped     <= 1'b0;
    end else begin
      exe_q <= execute[0];
      if (launch && (state != ST_IDLE)) dropped <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (launch) begin
            a_q  <= A_reg;
            b_q  <= B_reg;
            op_q <= alu_op_e'(OPER[2:0]);
            busy <= 1'b1;
`ifdef ALU_EXEC_MUL_EN
            state <= (OPER[2:0] == OP_MUL) ? ST_MUL : ST_CALC;
`else
            state <= ST_CALC;
`endif
          end
        end
        ST_CALC: begin
          res_data    <= calc_data;
          res_carry   <= calc_carry;
          res_zero    <= (calc_data == '0);
          res_illegal <= calc_ill;
          res_valid   <= 1'b1;
          state       <= ST_DONE;
        end
        ST_MUL: begin
`ifdef ALU_EXEC_MUL_EN
          if (mul_done) begin
            res_data    <= mul_product;
            res_carry   <= 1'b0;
            res_zero    <= (mul_product == '0);
            res_illegal <= 1'b0;
            res_valid   <= 1'b1;
            state       <= ST_DONE;
          end
`else
          state <= ST_IDLE;
          busy  <= 1'b0;
`endif
        end
        ST_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec: vector table, hand-written handshake/drop/reset sequences, and random ops
// checked against an arithmetic reference model.
module tb_alu_exec;

  localparam int W = 8;
`ifdef ALU_EXEC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  A_reg;
  logic [W-1:0]  B_reg;
  logic [W-1:0]  OPER;
  logic [16:0]   execute;
  logic [2*W-1:0] res_data;
  logic          res_carry;
  logic          res_zero;
  logic          res_illegal;
  logic          res_valid;
  logic          res_ready;
  logic          busy;
  logic          dropped;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    int         d;
    bit         c;
    bit         z;
    bit         il;
  } vec_t;

  vec_t vecs[$];

  alu_exec #(.DATA_WIDTH(W), .EXEC_WIDTH(17)) dut (
    .clk         (clk),
    .rst         (rst),
    .A_reg       (A_reg),
    .B_reg       (B_reg),
    .OPER        (OPER),
    .execute     (execute),
    .res_data    (res_data),
    .res_carry   (res_carry),
    .res_zero    (res_zero),
    .res_illegal (res_illegal),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .busy        (busy),
    .dropped     (dropped)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model straight from the opcode definitions, in integer arithmetic.
  function automatic void model(input int a, input int b, input int op,
                                output int d, output bit c, output bit z, output bit il);
    int sh;
    int m;
    m  = 1 << W;
    sh = b % W;
    d  = 0;
    c  = 1'b0;
    il = 1'b0;
    case (op)
      0: begin d = a + b; c = (a + b) >= m; end
      1: begin d = (a - b + m) % m; c = (a < b); end
      2: d = a & b;
      3: d = a | b;
      4: d = a ^ b;
      5: if (MUL_EN) d = a * b; else il = 1'b1;
      6: d = a * (1 << sh);
      7: d = a / (1 << sh);
      default: d = 0;
    endcase
    z = (d == 0);
  endfunction

  function automatic int exp_latency(input logic [2:0] op);
    return (op == 3'd5 && MUL_EN) ? W + 1 : 2;
  endfunction

  function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                              input int d, input bit c, input bit z, input bit il);
    vec_t v;
    v.a = a; v.b = b; v.op = op; v.d = d; v.c = c; v.z = z; v.il = il;
    return v;
  endfunction

  // Pulse execute[0] with the given operands and wait (bounded) for res_valid; lat counts edges.
  task automatic launch_wait(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                             input bit early, output int lat);
    A_reg   = a;
    B_reg   = b;
    OPER    = {5'($urandom), op};
    execute = {16'($urandom), 1'b1};
    tick();
    execute = '0;
    A_reg   = 8'($urandom);
    B_reg   = 8'($urandom);
    OPER    = 8'($urandom);
    if (early) res_ready = 1'b1;
    lat = 1;
    while (res_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op, input int ed, input bit ec, input bit ez,
                        input bit ei, input int hold, input bit early);
    int lat;
    res_ready = 1'b0;
    launch_wait(a, b, op, early, lat);
    chk({name, "_lat"}, lat, exp_latency(op));
    chk({name, "_data"}, int'(res_data), ed);
    chk({name, "_carry"}, int'(res_carry), int'(ec));
    chk({name, "_zero"}, int'(res_zero), int'(ez));
    chk({name, "_illegal"}, int'(res_illegal), int'(ei));
    chk({name, "_busy"}, int'(busy), 1);
    if (!early) begin
      for (int h = 0; h < hold; h++) begin
        tick();
        chk({name, "_hold_valid"}, int'(res_valid), 1);
        chk({name, "_hold_data"}, int'(res_data), ed);
      end
      res_ready = 1'b1;
    end
    tick();
    chk({name, "_after_valid"}, int'(res_valid), 0);
    chk({name, "_after_busy"}, int'(busy), 0);
    res_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic count_valid(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (res_valid === 1'b1) n++;
    end
  endtask

  initial begin
    int lat;
    int n;
    int ed;
    bit ec, ez, ei;
    logic [7:0] ra, rb;
    logic [2:0] rop;

    rst       = 1'b0;
    A_reg     = '0;
    B_reg     = '0;
    OPER      = '0;
    execute   = '0;
    res_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;

    chk("rst_data", int'(res_data), 0);
    chk("rst_carry", int'(res_carry), 0);
    chk("rst_zero", int'(res_zero), 0);
    chk("rst_illegal", int'(res_illegal), 0);
    chk("rst_valid", int'(res_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_dropped", int'(dropped), 0);

    vecs.push_back(mk(8'hF0, 8'h20, 3'd0, 'h0110, 1, 0, 0));
    vecs.push_back(mk(8'hFF, 8'h01, 3'd0, 'h0100, 1, 0, 0));
    vecs.push_back(mk(8'h00, 8'h00, 3'd0, 'h0000, 0, 1, 0));
    vecs.push_back(mk(8'h05, 8'h05, 3'd1, 'h0000, 0, 1, 0));
    vecs.push_back(mk(8'h03, 8'h05, 3'd1, 'h00FE, 1, 0, 0));
    vecs.push_back(mk(8'h80, 8'h01, 3'd1, 'h007F, 0, 0, 0));
    vecs.push_back(mk(8'hF0, 8'h3C, 3'd2, 'h0030, 0, 0, 0));
    vecs.push_back(mk(8'hF0, 8'h0F, 3'd3, 'h00FF, 0, 0, 0));
    vecs.push_back(mk(8'hAA, 8'hAA, 3'd4, 'h0000, 0, 1, 0));
    vecs.push_back(mk(8'h81, 8'h03, 3'd6, 'h0408, 0, 0, 0));
    vecs.push_back(mk(8'hFF, 8'h0F, 3'd6, 'h7F80, 0, 0, 0));
    vecs.push_back(mk(8'h81, 8'h0B, 3'd7, 'h0010, 0, 0, 0));
    vecs.push_back(mk(8'h80, 8'h07, 3'd7, 'h0001, 0, 0, 0));
`ifdef ALU_EXEC_MUL_EN
    vecs.push_back(mk(8'hFF, 8'hFF, 3'd5, 'hFE01, 0, 0, 0));
    vecs.push_back(mk(8'h00, 8'hFF, 3'd5, 'h0000, 0, 1, 0));
    vecs.push_back(mk(8'h0D, 8'h0B, 3'd5, 'h008F, 0, 0, 0));
`else
    vecs.push_back(mk(8'hFF, 8'hFF, 3'd5, 'h0000, 0, 1, 1));
    vecs.push_back(mk(8'h0D, 8'h0B, 3'd5, 'h0000, 0, 1, 1));
`endif

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].d,
             vecs[i].c, vecs[i].z, vecs[i].il, i % 3, (i % 4) == 3);

    // Backpressure: five cycles of res_ready low with stable outputs.
    run_op("bp", 8'hF0, 8'h20, 3'd0, 'h0110, 1, 0, 0, 5, 0);

    // execute[0] held high for 20 cycles launches exactly once.
    A_reg = 8'h01; B_reg = 8'h02; OPER = 8'h00; res_ready = 1'b1; execute = 17'h1;
    count_valid(20, n);
    execute = '0;
    count_valid(5, lat);
    chk("hold_exec_results", n + lat, 1);
    chk("hold_exec_dropped", int'(dropped), 0);
    res_ready = 1'b0;

    // Relaunch while in DONE is dropped and produces no second result.
    launch_wait(8'h10, 8'h20, 3'd0, 0, lat);
    chk("drop_first_lat", lat, 2);
    execute = 17'h1;
    tick();
    execute = '0;
    chk("drop_flag", int'(dropped), 1);
    chk("drop_inflight_data", int'(res_data), 'h30);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    count_valid(15, n);
    chk("drop_no_second", n, 0);
    chk("drop_sticky", int'(dropped), 1);

    // Launch on the accepting edge is also dropped.
    do_reset();
    chk("reset_clears_dropped", int'(dropped), 0);
    launch_wait(8'h01, 8'h01, 3'd0, 0, lat);
    chk("accedge_lat", lat, 2);
    res_ready = 1'b1;
    execute   = 17'h1;
    tick();
    execute   = '0;
    res_ready = 1'b0;
    chk("accedge_valid", int'(res_valid), 0);
    chk("accedge_dropped", int'(dropped), 1);
    count_valid(15, n);
    chk("accedge_no_result", n, 0);

    // Reset in the middle of an operation discards it.
`ifdef ALU_EXEC_MUL_EN
    A_reg = 8'hFF; B_reg = 8'hFF; OPER = 8'h05; execute = 17'h1;
    tick();
    execute = '0;
    repeat (3) tick();
`else
    launch_wait(8'hFF, 8'hFF, 3'd5, 0, lat);
`endif
    do_reset();
    chk("midrst_data", int'(res_data), 0);
    chk("midrst_zero", int'(res_zero), 0);
    chk("midrst_carry", int'(res_carry), 0);
    chk("midrst_illegal", int'(res_illegal), 0);
    chk("midrst_valid", int'(res_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_dropped", int'(dropped), 0);
    count_valid(15, n);
    chk("midrst_no_result", n, 0);
    run_op("post_rst_shl", 8'h81, 8'h03, 3'd6, 'h0408, 0, 0, 0, 1, 0);

    for (int i = 0; i < 40; i++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rop = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) ra = 8'hFF;
      if ($urandom_range(0, 5) == 0) rb = ra;
      model(int'(ra), int'(rb), int'(rop), ed, ec, ez, ei);
      run_op($sformatf("rnd%0d", i), ra, rb, rop, ed, ec, ez, ei,
             $urandom_range(0, 3), $urandom_range(0, 1) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
